// File: rtl/pipeline_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_unit
//
// Control path for the rv32im_zbb 5-stage core. It carries a decoded control
// word and register metadata from ID through EX, MEM and WB. It also produces:
//   - load-use and branch-operand stalls,
//   - multi-cycle EX back-pressure (mul/div),
//   - the taken-branch IF/ID flush,
//   - the EX operand forwarding selects,
//   - saturating stall/flush performance counters.
//
// Ports
//   clk, rst_n              clock; asynchronous active-low reset
//   id_valid_i              ID holds a valid instruction
//   id_ctrl_i               decoded control word from ID
//   id_rd_i/rs1_i/rs2_i     destination / source register addresses
//   id_rd_we_i, id_load_i   writes rd / result comes from data memory
//   id_rs1_use_i/rs2_use_i  source operand is actually read
//   id_is_branch_i          operands are compared/used in ID
//   id_branch_taken_i       branch/jump resolved taken in ID
//   ex_busy_i               multi-cycle EX unit still working
//   cnt_clr_i               synchronous clear of both counters
//   ex/mem/wb_ctrl_o        per-stage control words
//   ex/mem/wb_valid_o       per-stage valid bits
//   wb_rd_o, wb_rd_we_o,
//   wb_load_o               write-back controls
//   fwd_a_o, fwd_b_o        EX operand select: 00 regfile, 01 WB, 10 MEM ALU
//   pc_en_o, if_id_en_o     PC and IF/ID register enables
//   if_id_flush_o           squash the wrong-path instruction in IF/ID
//   stall_cnt_o,
//   flush_cnt_o             saturating performance counters
// ---------------------------------------------------------------------------
module pipeline_ctrl_unit #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [4:0]        id_rd_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic              id_rd_we_i,
  input  logic              id_load_i,
  input  logic              id_rs1_use_i,
  input  logic              id_rs2_use_i,
  input  logic              id_is_branch_i,
  input  logic              id_branch_taken_i,
  input  logic              ex_busy_i,
  input  logic              cnt_clr_i,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [CTRL_W-1:0] mem_ctrl_o,
  output logic [CTRL_W-1:0] wb_ctrl_o,
  output logic              ex_valid_o,
  output logic              mem_valid_o,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic              wb_rd_we_o,
  output logic              wb_load_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              pc_en_o,
  output logic              if_id_en_o,
  output logic              if_id_flush_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [4:0] REG_X0  = 5'd0;

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    sat_inc = (&v) ? v : v + one;
  endfunction

  // Operand select for one EX source. The MEM match is tested first so that
  // the youngest producer wins. A load in MEM has no result yet and is never
  // forwarded from there.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       mem_wr,
    input logic       mem_ld,
    input logic [4:0] mem_rd,
    input logic       wb_wr,
    input logic [4:0] wb_rd
  );
    if (mem_wr && !mem_ld && (mem_rd == rs))
      fwd_sel = FWD_MEM;
    else if (wb_wr && (wb_rd == rs))
      fwd_sel = FWD_WB;
    else
      fwd_sel = FWD_RF;
  endfunction

  // Stage registers: p0 = ID/EX, p1 = EX/MEM, p2 = MEM/WB.
  // Source addresses are only consumed by forwarding in EX, so they are not
  // carried any further down the pipe.
  logic              vld_p0, vld_p1, vld_p2;
  logic [CTRL_W-1:0] ctrl_p0, ctrl_p1, ctrl_p2;
  logic [4:0]        rd_p0, rd_p1, rd_p2;
  logic              rd_we_p0, rd_we_p1, rd_we_p2;
  logic              load_p0, load_p1, load_p2;
  logic [4:0]        rs1_p0, rs2_p0;

  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  // Hazard detection
  logic eff_wr_p0, eff_wr_p1, eff_wr_p2;
  logic src_hit_p0, src_hit_p1;
  logic load_use, br_haz, stall_id;
  logic pc_en, flush;

  // A writer to x0 is architecturally a no-op, so it never creates a hazard.
  assign eff_wr_p0 = vld_p0 & rd_we_p0 & (rd_p0 != REG_X0);
  assign eff_wr_p1 = vld_p1 & rd_we_p1 & (rd_p1 != REG_X0);
  assign eff_wr_p2 = vld_p2 & rd_we_p2 & (rd_p2 != REG_X0);

  assign src_hit_p0 = (id_rs1_use_i & (id_rs1_i == rd_p0)) |
                      (id_rs2_use_i & (id_rs2_i == rd_p0));
  assign src_hit_p1 = (id_rs1_use_i & (id_rs1_i == rd_p1)) |
                      (id_rs2_use_i & (id_rs2_i == rd_p1));

  assign load_use = id_valid_i & eff_wr_p0 & load_p0 & src_hit_p0;

  // A branch compares in ID, so it must also wait for any ALU result still in
  // EX and for a load result that is still in MEM.
  assign br_haz = id_valid_i & id_is_branch_i &
                  ((eff_wr_p0 & src_hit_p0) | (eff_wr_p1 & load_p1 & src_hit_p1));

  assign stall_id = load_use | br_haz;

  assign pc_en = ~(ex_busy_i | stall_id);
  assign flush = id_valid_i & id_branch_taken_i & ~stall_id & ~ex_busy_i;

  assign pc_en_o       = pc_en;
  assign if_id_en_o    = pc_en;
  assign if_id_flush_o = flush;

  assign fwd_a_o = fwd_sel(rs1_p0, eff_wr_p1, load_p1, rd_p1, eff_wr_p2, rd_p2);
  assign fwd_b_o = fwd_sel(rs2_p0, eff_wr_p1, load_p1, rd_p1, eff_wr_p2, rd_p2);

  // ---- ID -> EX boundary ----
  // Busy holds the EX instruction in place. A stall without busy inserts a
  // bubble. Otherwise the ID contents are captured with ID's valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      ctrl_p0  <= '0;
      rd_p0    <= '0;
      rd_we_p0 <= 1'b0;
      load_p0  <= 1'b0;
      rs1_p0   <= '0;
      rs2_p0   <= '0;
    end else if (ex_busy_i) begin
      vld_p0   <= vld_p0;
      ctrl_p0  <= ctrl_p0;
      rd_p0    <= rd_p0;
      rd_we_p0 <= rd_we_p0;
      load_p0  <= load_p0;
      rs1_p0   <= rs1_p0;
      rs2_p0   <= rs2_p0;
    end else if (stall_id) begin
      vld_p0   <= 1'b0;
      ctrl_p0  <= '0;
      rd_p0    <= '0;
      rd_we_p0 <= 1'b0;
      load_p0  <= 1'b0;
      rs1_p0   <= '0;
      rs2_p0   <= '0;
    end else begin
      vld_p0   <= id_valid_i;
      ctrl_p0  <= id_ctrl_i;
      rd_p0    <= id_rd_i;
      rd_we_p0 <= id_rd_we_i;
      load_p0  <= id_load_i;
      rs1_p0   <= id_rs1_i;
      rs2_p0   <= id_rs2_i;
    end
  end

  // ---- EX -> MEM boundary ----
  // While EX is busy its instruction has not produced a result, so MEM
  // receives a bubble each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      ctrl_p1  <= '0;
      rd_p1    <= '0;
      rd_we_p1 <= 1'b0;
      load_p1  <= 1'b0;
    end else if (ex_busy_i) begin
      vld_p1   <= 1'b0;
      ctrl_p1  <= '0;
      rd_p1    <= '0;
      rd_we_p1 <= 1'b0;
      load_p1  <= 1'b0;
    end else begin
      vld_p1   <= vld_p0;
      ctrl_p1  <= ctrl_p0;
      rd_p1    <= rd_p0;
      rd_we_p1 <= rd_we_p0;
      load_p1  <= load_p0;
    end
  end

  // ---- MEM -> WB boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      ctrl_p2  <= '0;
      rd_p2    <= '0;
      rd_we_p2 <= 1'b0;
      load_p2  <= 1'b0;
    end else begin
      vld_p2   <= vld_p1;
      ctrl_p2  <= ctrl_p1;
      rd_p2    <= rd_p1;
      rd_we_p2 <= rd_we_p1;
      load_p2  <= load_p1;
    end
  end

  // Counters: clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en) stall_cnt <= sat_inc(stall_cnt);
      if (flush)  flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign ex_ctrl_o   = ctrl_p0;
  assign mem_ctrl_o  = ctrl_p1;
  assign wb_ctrl_o   = ctrl_p2;
  assign ex_valid_o  = vld_p0;
  assign mem_valid_o = vld_p1;
  assign wb_valid_o  = vld_p2;
  assign wb_rd_o     = rd_p2;
  assign wb_rd_we_o  = vld_p2 & rd_we_p2;
  assign wb_load_o   = vld_p2 & load_p2;
  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
module tb_pipeline_ctrl_unit;

  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              id_valid_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic [4:0]        id_rd_i, id_rs1_i, id_rs2_i;
  logic              id_rd_we_i, id_load_i, id_rs1_use_i, id_rs2_use_i;
  logic              id_is_branch_i, id_branch_taken_i;
  logic              ex_busy_i, cnt_clr_i;
  logic [CTRL_W-1:0] ex_ctrl_o, mem_ctrl_o, wb_ctrl_o;
  logic              ex_valid_o, mem_valid_o, wb_valid_o;
  logic [4:0]        wb_rd_o;
  logic              wb_rd_we_o, wb_load_o;
  logic [1:0]        fwd_a_o, fwd_b_o;
  logic              pc_en_o, if_id_en_o, if_id_flush_o;
  logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl_unit #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i),
    .id_rd_i(id_rd_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rd_we_i(id_rd_we_i), .id_load_i(id_load_i),
    .id_rs1_use_i(id_rs1_use_i), .id_rs2_use_i(id_rs2_use_i),
    .id_is_branch_i(id_is_branch_i), .id_branch_taken_i(id_branch_taken_i),
    .ex_busy_i(ex_busy_i), .cnt_clr_i(cnt_clr_i),
    .ex_ctrl_o(ex_ctrl_o), .mem_ctrl_o(mem_ctrl_o), .wb_ctrl_o(wb_ctrl_o),
    .ex_valid_o(ex_valid_o), .mem_valid_o(mem_valid_o), .wb_valid_o(wb_valid_o),
    .wb_rd_o(wb_rd_o), .wb_rd_we_o(wb_rd_we_o), .wb_load_o(wb_load_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
    .pc_en_o(pc_en_o), .if_id_en_o(if_id_en_o), .if_id_flush_o(if_id_flush_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic we, input logic ld,
                     input logic u1, input logic u2, input logic br,
                     input logic tk, input logic [CTRL_W-1:0] ctrl);
    id_valid_i = v; id_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
    id_rd_we_i = we; id_load_i = ld; id_rs1_use_i = u1; id_rs2_use_i = u2;
    id_is_branch_i = br; id_branch_taken_i = tk; id_ctrl_i = ctrl;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
  endtask

  // Empty every stage and zero the counters; returns just after an edge.
  task automatic drain();
    idle();
    ex_busy_i = 0;
    cnt_clr_i = 1;
    repeat (3) cyc();
    cnt_clr_i = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL rst_ex_valid got %b want 0", ex_valid_o); end
    checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got %b want 0", mem_valid_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got %b want 0", wb_valid_o); end
    checks++; if (pc_en_o !== 1'b1 || if_id_en_o !== 1'b1) begin errors++; $display("FAIL rst_enables got %b%b want 11", pc_en_o, if_id_en_o); end
    checks++; if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00) begin errors++; $display("FAIL rst_fwd got %b/%b want 00/00", fwd_a_o, fwd_b_o); end
    checks++; if (wb_rd_we_o !== 1'b0) begin errors++; $display("FAIL rst_wb_rd_we got %b want 0", wb_rd_we_o); end
    checks++; if (stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0) begin errors++; $display("FAIL rst_counters got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o); end
    checks++; if (ex_ctrl_o !== 16'h0 || wb_ctrl_o !== 16'h0) begin errors++; $display("FAIL rst_ctrl got %h/%h want 0/0", ex_ctrl_o, wb_ctrl_o); end
    // Flush follows the ID inputs even while in reset.
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0000);
    #1;
    checks++; if (if_id_flush_o !== 1'b1) begin errors++; $display("FAIL rst_flush_comb got %b want 1", if_id_flush_o); end
    idle();
    rst_n = 1;
  endtask

  task automatic test_load_use();
    drain();
    drv(1, 5, 1, 0, 1, 1, 1, 0, 0, 0, 16'h00A1);   // lw x5,0(x1)
    cyc();
    drv(1, 6, 5, 1, 1, 0, 1, 1, 0, 0, 16'h00A2);   // add x6,x5,x1
    #1;
    checks++; if (pc_en_o !== 1'b0 || if_id_en_o !== 1'b0) begin errors++; $display("FAIL lu_stall got %b%b want 00", pc_en_o, if_id_en_o); end
    checks++; if (ex_valid_o !== 1'b1) begin errors++; $display("FAIL lu_lw_in_ex got %b want 1", ex_valid_o); end
    cyc();
    #1;
    checks++; if (pc_en_o !== 1'b1) begin errors++; $display("FAIL lu_release got %b want 1", pc_en_o); end
    checks++; if (ex_valid_o !== 1'b0 || mem_valid_o !== 1'b1) begin errors++; $display("FAIL lu_bubble ex/mem got %b/%b want 0/1", ex_valid_o, mem_valid_o); end
    cyc();
    idle();
    #1;
    checks++; if (ex_valid_o !== 1'b1 || ex_ctrl_o !== 16'h00A2) begin errors++; $display("FAIL lu_add_in_ex got %b/%h want 1/00a2", ex_valid_o, ex_ctrl_o); end
    checks++; if (fwd_a_o !== 2'b01 || fwd_b_o !== 2'b00) begin errors++; $display("FAIL lu_fwd got %b/%b want 01/00", fwd_a_o, fwd_b_o); end
    checks++; if (wb_rd_o !== 5'd5 || wb_rd_we_o !== 1'b1 || wb_load_o !== 1'b1) begin errors++; $display("FAIL lu_wb got rd=%0d we=%b ld=%b want 5/1/1", wb_rd_o, wb_rd_we_o, wb_load_o); end
    checks++; if (stall_cnt_o !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt_o); end
  endtask

  task automatic test_forward();
    // Two producers of x3: the MEM copy is younger and must win.
    drain();
    drv(1, 3, 1, 0, 1, 0, 1, 0, 0, 0, 16'h0011); cyc();
    drv(1, 3, 2, 0, 1, 0, 1, 0, 0, 0, 16'h0012); #1;
    checks++; if (pc_en_o !== 1'b1) begin errors++; $display("FAIL fw_nostall1 got %b want 1", pc_en_o); end
    cyc();
    drv(1, 4, 3, 3, 1, 0, 1, 1, 0, 0, 16'h0013); #1;
    checks++; if (pc_en_o !== 1'b1) begin errors++; $display("FAIL fw_nostall2 got %b want 1", pc_en_o); end
    cyc();
    idle(); #1;
    checks++; if (fwd_a_o !== 2'b10 || fwd_b_o !== 2'b10) begin errors++; $display("FAIL fw_mem_wins got %b/%b want 10/10", fwd_a_o, fwd_b_o); end
    checks++; if (stall_cnt_o !== 4'd0) begin errors++; $display("FAIL fw_stall_cnt got %0d want 0", stall_cnt_o); end
    // Same sequence targeting x0: nothing is forwarded.
    drain();
    drv(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 16'h0021); cyc();
    drv(1, 0, 2, 0, 1, 0, 1, 0, 0, 0, 16'h0022); cyc();
    drv(1, 4, 0, 0, 1, 0, 1, 1, 0, 0, 16'h0023); #1;
    checks++; if (pc_en_o !== 1'b1) begin errors++; $display("FAIL fw_x0_nostall got %b want 1", pc_en_o); end
    cyc();
    idle(); #1;
    checks++; if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00) begin errors++; $display("FAIL fw_x0 got %b/%b want 00/00", fwd_a_o, fwd_b_o); end
    // Producer only in WB (gap of one empty slot): select 01 on rs1 only.
    drain();
    drv(1, 3, 1, 0, 1, 0, 1, 0, 0, 0, 16'h0031); cyc();
    idle(); cyc();
    drv(1, 4, 3, 2, 1, 0, 1, 1, 0, 0, 16'h0033); cyc();
    idle(); #1;
    checks++; if (fwd_a_o !== 2'b01 || fwd_b_o !== 2'b00) begin errors++; $display("FAIL fw_wb_only got %b/%b want 01/00", fwd_a_o, fwd_b_o); end
  endtask

  task automatic test_branch();
    drain();
    drv(1, 7, 1, 0, 1, 0, 1, 0, 0, 0, 16'h0041); cyc();   // addi x7
    drv(1, 0, 7, 0, 0, 0, 1, 1, 1, 1, 16'h0042); #1;      // beq x7,x0 taken
    checks++; if (pc_en_o !== 1'b0 || if_id_flush_o !== 1'b0) begin errors++; $display("FAIL br_stall got pc_en=%b flush=%b want 0/0", pc_en_o, if_id_flush_o); end
    cyc(); #1;
    checks++; if (pc_en_o !== 1'b1 || if_id_flush_o !== 1'b1) begin errors++; $display("FAIL br_flush got pc_en=%b flush=%b want 1/1", pc_en_o, if_id_flush_o); end
    cyc();
    idle(); #1;
    checks++; if (if_id_flush_o !== 1'b0 || ex_ctrl_o !== 16'h0042) begin errors++; $display("FAIL br_advance got flush=%b ex_ctrl=%h want 0/0042", if_id_flush_o, ex_ctrl_o); end
    checks++; if (flush_cnt_o !== 4'd1 || stall_cnt_o !== 4'd1) begin errors++; $display("FAIL br_counts got %0d/%0d want 1/1", flush_cnt_o, stall_cnt_o); end
    // Branch on a load result: waits for EX and then MEM, two stall cycles.
    drain();
    drv(1, 8, 1, 0, 1, 1, 1, 0, 0, 0, 16'h0051); cyc();   // lw x8
    drv(1, 0, 8, 0, 0, 0, 1, 1, 1, 0, 16'h0052); #1;      // beq x8,x0 not taken
    checks++; if (pc_en_o !== 1'b0) begin errors++; $display("FAIL brld_stall1 got %b want 0", pc_en_o); end
    cyc(); #1;
    checks++; if (pc_en_o !== 1'b0 || ex_valid_o !== 1'b0) begin errors++; $display("FAIL brld_stall2 got pc_en=%b ex_valid=%b want 0/0", pc_en_o, ex_valid_o); end
    cyc(); #1;
    checks++; if (pc_en_o !== 1'b1 || stall_cnt_o !== 4'd2) begin errors++; $display("FAIL brld_release got pc_en=%b cnt=%0d want 1/2", pc_en_o, stall_cnt_o); end
    checks++; if (if_id_flush_o !== 1'b0) begin errors++; $display("FAIL brld_noflush got %b want 0", if_id_flush_o); end
  endtask

  task automatic test_busy();
    drain();
    drv(1, 12, 1, 2, 1, 0, 1, 1, 0, 0, 16'hABCD); cyc();  // mul x12
    ex_busy_i = 1;
    drv(1, 0, 3, 4, 0, 0, 1, 1, 1, 1, 16'h1111); #1;      // taken beq behind it
    checks++; if (pc_en_o !== 1'b0 || if_id_flush_o !== 1'b0) begin errors++; $display("FAIL busy_hold got pc_en=%b flush=%b want 0/0", pc_en_o, if_id_flush_o); end
    checks++; if (ex_ctrl_o !== 16'hABCD) begin errors++; $display("FAIL busy_ex_ctrl1 got %h want abcd", ex_ctrl_o); end
    cyc(); #1;
    checks++; if (ex_ctrl_o !== 16'hABCD || mem_valid_o !== 1'b0 || mem_ctrl_o !== 16'h0) begin errors++; $display("FAIL busy_bubble got ex=%h mv=%b mc=%h want abcd/0/0000", ex_ctrl_o, mem_valid_o, mem_ctrl_o); end
    cyc(); #1;
    checks++; if (wb_valid_o !== 1'b0 || stall_cnt_o !== 4'd2) begin errors++; $display("FAIL busy_mid got wbv=%b cnt=%0d want 0/2", wb_valid_o, stall_cnt_o); end
    cyc();
    ex_busy_i = 0; #1;
    checks++; if (stall_cnt_o !== 4'd3 || ex_ctrl_o !== 16'hABCD || ex_valid_o !== 1'b1) begin errors++; $display("FAIL busy_end got cnt=%0d ex=%h ev=%b want 3/abcd/1", stall_cnt_o, ex_ctrl_o, ex_valid_o); end
    checks++; if (pc_en_o !== 1'b1 || if_id_flush_o !== 1'b1 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL busy_resume got pc_en=%b flush=%b wbv=%b want 1/1/0", pc_en_o, if_id_flush_o, wb_valid_o); end
    cyc();
    idle(); #1;
    checks++; if (mem_ctrl_o !== 16'hABCD || ex_ctrl_o !== 16'h1111 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL busy_adv got mc=%h ec=%h wbv=%b want abcd/1111/0", mem_ctrl_o, ex_ctrl_o, wb_valid_o); end
    checks++; if (flush_cnt_o !== 4'd1) begin errors++; $display("FAIL busy_flush_cnt got %0d want 1", flush_cnt_o); end
    cyc(); #1;
    checks++; if (wb_valid_o !== 1'b1 || wb_ctrl_o !== 16'hABCD || wb_rd_o !== 5'd12) begin errors++; $display("FAIL busy_wb got v=%b c=%h rd=%0d want 1/abcd/12", wb_valid_o, wb_ctrl_o, wb_rd_o); end
  endtask

  task automatic test_saturation();
    drain();
    ex_busy_i = 1;
    repeat (20) cyc();
    #1;
    checks++; if (stall_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_stall got %0d want 15", stall_cnt_o); end
    cnt_clr_i = 1;                 // clear coincides with a stall cycle
    cyc();
    cnt_clr_i = 0; #1;
    checks++; if (stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0) begin errors++; $display("FAIL sat_clear got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o); end
    cyc(); #1;
    checks++; if (stall_cnt_o !== 4'd1) begin errors++; $display("FAIL sat_recount got %0d want 1", stall_cnt_o); end
    ex_busy_i = 0;
  endtask

  task automatic test_reset_mid_busy();
    drain();
    drv(1, 12, 1, 2, 1, 0, 1, 1, 0, 0, 16'h5A5A); cyc();
    ex_busy_i = 1;
    idle();
    cyc(); cyc(); #1;
    checks++; if (ex_valid_o !== 1'b1 || stall_cnt_o !== 4'd2) begin errors++; $display("FAIL rmb_pre got ev=%b cnt=%0d want 1/2", ex_valid_o, stall_cnt_o); end
    #1 rst_n = 0;
    #1;
    checks++; if (ex_valid_o !== 1'b0 || mem_valid_o !== 1'b0 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL rmb_valids got %b%b%b want 000", ex_valid_o, mem_valid_o, wb_valid_o); end
    checks++; if (stall_cnt_o !== 4'd0 || ex_ctrl_o !== 16'h0) begin errors++; $display("FAIL rmb_clear got cnt=%0d ctrl=%h want 0/0000", stall_cnt_o, ex_ctrl_o); end
    ex_busy_i = 0;
    #1 rst_n = 1;
    #1;
    checks++; if (pc_en_o !== 1'b1) begin errors++; $display("FAIL rmb_pc_en got %b want 1", pc_en_o); end
    cyc(); #1;
    checks++; if (ex_valid_o !== 1'b0 || stall_cnt_o !== 4'd0) begin errors++; $display("FAIL rmb_no_replay got ev=%b cnt=%0d want 0/0", ex_valid_o, stall_cnt_o); end
  endtask

  initial begin
    rst_n = 0;
    ex_busy_i = 0;
    cnt_clr_i = 0;
    idle();
    test_reset();
    cyc();
    test_load_use();
    test_forward();
    test_branch();
    test_busy();
    test_saturation();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
